// File: rtl/i2c_slave_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_rx_if
// Description : Bundle of the bus lines and receive-side outputs of
//               i2c_slave_rx. The slave modport is the receiver's view; the
//               master modport is the view of whatever drives SCL/SDA and
//               consumes the received bytes.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_rx_if;
  logic       scl;
  logic       sda;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl, sda,
    output sda_oe, rx_data, rx_valid, addr_match, start_det, stop_det, busy
  );

  modport master (
    output scl, sda,
    input  sda_oe, rx_data, rx_valid, addr_match, start_det, stop_det, busy
  );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_rx
// Description : Byte-level I2C slave receiver. Oversamples SCL/SDA on clk,
//               detects START/STOP, ACKs a matching write address and then
//               delivers each received data byte with a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2      // must be 2 or more
) (
  input  logic          clk,
  input  logic          rst_n,
  i2c_slave_rx_if.slave bus
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ADDR     = 3'd1;
  localparam logic [2:0] c_ADDR_CHK = 3'd2;
  localparam logic [2:0] c_ADDR_ACK = 3'd3;
  localparam logic [2:0] c_DATA     = 3'd4;
  localparam logic [2:0] c_DATA_ACK = 3'd5;
  localparam logic [2:0] c_IGNORE   = 3'd6;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl_s, w_sda_s;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

  logic [2:0] r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_bit_done, w_bit_done_nxt;
  logic       w_byte_end;

  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_addr_match, w_addr_match_nxt;
  logic       r_start_det, w_start_det_nxt;
  logic       r_stop_det, w_stop_det_nxt;
  logic       r_busy, w_busy_nxt;

  // Synchronize the bus lines and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda_s & w_scl_s & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda_s & w_scl_s & r_scl_d;
  // The done flag stops a ninth rise from being taken as another bit.
  assign w_byte_end = w_scl_rise & (r_bit_cnt == 3'd7) & ~r_bit_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; START beats STOP and both beat every state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = c_ADDR;
    end else if (w_stop) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_ADDR:     if (w_byte_end) w_state_nxt = c_ADDR_CHK;
        c_ADDR_CHK: w_state_nxt = (r_shift[7:1] == SLAVE_ADDR && !r_shift[0])
                                  ? c_ADDR_ACK : c_IGNORE;
        // Second SCL fall while driving ends the ACK clock.
        c_ADDR_ACK,
        c_DATA_ACK: if (w_scl_fall && r_sda_oe) w_state_nxt = c_DATA;
        c_DATA:     if (w_byte_end) w_state_nxt = c_DATA_ACK;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  // Output/datapath next values; sda_oe only ever moves on an SCL fall.
  always_comb begin
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_bit_done_nxt   = r_bit_done;
    w_sda_oe_nxt     = r_sda_oe;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = 1'b0;
    w_addr_match_nxt = r_addr_match;
    w_start_det_nxt  = 1'b0;
    w_stop_det_nxt   = 1'b0;
    w_busy_nxt       = r_busy;
    if (w_start) begin
      w_start_det_nxt  = 1'b1;
      w_busy_nxt       = 1'b1;
      w_sda_oe_nxt     = 1'b0;
      w_addr_match_nxt = 1'b0;
      w_bit_cnt_nxt    = 3'd0;
      w_bit_done_nxt   = 1'b0;
    end else if (w_stop) begin
      w_stop_det_nxt   = 1'b1;
      w_busy_nxt       = 1'b0;
      w_sda_oe_nxt     = 1'b0;
      w_addr_match_nxt = 1'b0;
    end else begin
      case (r_state)
        c_ADDR, c_DATA: begin
          if (w_scl_rise && !r_bit_done) begin
            w_shift_nxt = {r_shift[6:0], w_sda_s};
            if (r_bit_cnt == 3'd7) begin
              w_bit_done_nxt = 1'b1;
              if (r_state == c_DATA) begin
                w_rx_data_nxt  = {r_shift[6:0], w_sda_s};
                w_rx_valid_nxt = 1'b1;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        c_ADDR_ACK, c_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
              if (r_state == c_ADDR_ACK) w_addr_match_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt   = 1'b0;
              w_bit_cnt_nxt  = 3'd0;
              w_bit_done_nxt = 1'b0;
            end
          end
        end
        c_IGNORE: w_sda_oe_nxt = 1'b0;
        default:  w_sda_oe_nxt = r_sda_oe;
      endcase
    end
  end

  // Datapath and output registers; async reset also releases SDA at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_bit_done   <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_addr_match <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_bit_done   <= w_bit_done_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_addr_match <= w_addr_match_nxt;
      r_start_det  <= w_start_det_nxt;
      r_stop_det   <= w_stop_det_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign bus.sda_oe     = r_sda_oe;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.addr_match = r_addr_match;
  assign bus.start_det  = r_start_det;
  assign bus.stop_det   = r_stop_det;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_rx
// Description : Self-checking bench for i2c_slave_rx. A bit-banged I2C
//               master drives transfers from a vector table plus hand-written
//               corner sequences; received bytes are checked via a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         nbytes;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_stop   = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[5];

  i2c_slave_rx_if bus ();

  // Open-drain line: the slave's pull-down wins over a released master.
  assign bus.scl = scl_drv;
  assign bus.sda = sda_drv & ~bus.sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rx_valid must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start_det) n_start++;
      if (bus.stop_det)  n_stop++;
      if (bus.rx_valid) begin
        chk("rx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic b);
    sda_drv = b;
    #60 scl_drv = 1'b1;
    #80 scl_drv = 1'b0;
    #40;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    #60 scl_drv = 1'b1;
    #40 sda_drv = 1'b0;
    #40 scl_drv = 1'b0;
    #40;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    #60 scl_drv = 1'b1;
    #40 sda_drv = 1'b1;
    #80;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1;
    #60 scl_drv = 1'b1;
    #40 ack = bus.sda_oe;
    #40 scl_drv = 1'b0;
    #40;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_sda_oe"}, 32'(bus.sda_oe), 32'd0);
    chk({tag, "_match"},  32'(bus.addr_match), 32'd0);
    chk({tag, "_queue"},  32'(exp_q.size()), 32'd0);
  endtask

  // Complete write transfer to 0x50 that must be ACKed throughout.
  task automatic good_write(input logic [7:0] d, input string tag);
    logic ack;
    i2c_start();
    send_byte({7'h50, 1'b0}, ack);
    chk({tag, "_addr_ack"}, 32'(ack), 32'd1);
    exp_q.push_back(d);
    send_byte(d, ack);
    chk({tag, "_data_ack"}, 32'(ack), 32'd1);
    i2c_stop();
    #60;
    check_idle(tag);
  endtask

  initial begin
    logic ack;
    int   s0, p0;

    vecs[0] = '{addr: 7'h50, rw: 1'b0, nbytes: 2, d0: 8'hA5, d1: 8'h3C, exp_ack: 1'b1};
    vecs[1] = '{addr: 7'h51, rw: 1'b0, nbytes: 2, d0: 8'h12, d1: 8'h34, exp_ack: 1'b0};
    vecs[2] = '{addr: 7'h50, rw: 1'b1, nbytes: 1, d0: 8'h55, d1: 8'h00, exp_ack: 1'b0};
    vecs[3] = '{addr: 7'h50, rw: 1'b0, nbytes: 1, d0: 8'h00, d1: 8'h00, exp_ack: 1'b1};
    vecs[4] = '{addr: 7'h50, rw: 1'b0, nbytes: 2, d0: 8'hFF, d1: 8'h80, exp_ack: 1'b1};

    rst_n = 1'b0;
    #100;
    chk("rst_sda_oe",   32'(bus.sda_oe), 32'd0);
    chk("rst_rx_data",  32'(bus.rx_data), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_match",    32'(bus.addr_match), 32'd0);
    chk("rst_start",    32'(bus.start_det), 32'd0);
    chk("rst_stop",     32'(bus.stop_det), 32'd0);
    chk("rst_busy",     32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    #100;

    // Table-driven transfers.
    for (int v = 0; v < 5; v++) begin
      s0 = n_start;
      p0 = n_stop;
      i2c_start();
      chk($sformatf("v%0d_start_det", v), 32'(n_start - s0), 32'd1);
      chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd1);
      send_byte({vecs[v].addr, vecs[v].rw}, ack);
      chk($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
      chk($sformatf("v%0d_match", v), 32'(bus.addr_match), 32'(vecs[v].exp_ack));
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        if (vecs[v].exp_ack) exp_q.push_back(b == 0 ? vecs[v].d0 : vecs[v].d1);
        send_byte(b == 0 ? vecs[v].d0 : vecs[v].d1, ack);
        chk($sformatf("v%0d_data%0d_ack", v, b), 32'(ack), 32'(vecs[v].exp_ack));
      end
      i2c_stop();
      #60;
      chk($sformatf("v%0d_stop_det", v), 32'(n_stop - p0), 32'd1);
      check_idle($sformatf("v%0d", v));
    end

    // Repeated START after a byte, then a new write of 0x01.
    s0 = n_start;
    i2c_start();
    send_byte({7'h50, 1'b0}, ack);
    chk("rs_addr_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, ack);
    chk("rs_match_before", 32'(bus.addr_match), 32'd1);
    i2c_start();
    chk("rs_match_dropped", 32'(bus.addr_match), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd1);
    send_byte({7'h50, 1'b0}, ack);
    chk("rs_addr2_ack", 32'(ack), 32'd1);
    chk("rs_match_again", 32'(bus.addr_match), 32'd1);
    exp_q.push_back(8'h01);
    send_byte(8'h01, ack);
    chk("rs_data_ack", 32'(ack), 32'd1);
    chk("rs_rx_data", 32'(bus.rx_data), 32'h01);
    i2c_stop();
    #60;
    chk("rs_start_count", 32'(n_start - s0), 32'd2);
    check_idle("rs");

    // STOP after five data bits discards the partial byte.
    i2c_start();
    send_byte({7'h50, 1'b0}, ack);
    chk("part_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    #60;
    check_idle("part");
    good_write(8'h3C, "after_part");

    // Reset while the slave is driving the address ACK.
    i2c_start();
    for (int i = 7; i >= 1; i--) send_bit(1'(7'h50 >> (i - 1)));
    send_bit(1'b0);
    sda_drv = 1'b1;
    #60 scl_drv = 1'b1;
    #40 chk("rstack_driving", 32'(bus.sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstack_sda_oe",   32'(bus.sda_oe), 32'd0);
    chk("rstack_match",    32'(bus.addr_match), 32'd0);
    chk("rstack_busy",     32'(bus.busy), 32'd0);
    chk("rstack_rx_data",  32'(bus.rx_data), 32'd0);
    chk("rstack_rx_valid", 32'(bus.rx_valid), 32'd0);
    #39 scl_drv = 1'b0;
    #40;
    i2c_stop();
    #40 rst_n = 1'b1;
    #100;
    good_write(8'h77, "after_rst");

    #200;
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
